// File: rtl/axi_mst_bridge.sv
// rtl/axi_mst_bridge.sv - native request/response to AXI4 master bridge, one transaction outstanding.
// Define AXI_MST_ERR_CHECK_EN to enable BRESP/RRESP, ID and burst-length checking on rsp_err_o.
module axi_mst_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wmask_i,
  input  logic [7:0]              req_len_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_last_o,
  output logic                    rsp_err_o,

  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARLOCK,
  output logic [3:0]              M_AXI_ARCACHE,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int                  STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0]          SIZE   = 3'($clog2(STRB_W));
  localparam logic [1:0]          INCR   = 2'b01;
  localparam logic [ID_WIDTH-1:0] ID     = ID_WIDTH'(AXI_ID);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wmask_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic                    aw_pend;
  logic                    w_pend;
  logic                    ar_pend;
  logic                    r_hs;

  assign r_hs = (state == RD_DATA) && M_AXI_RVALID && rsp_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      ar_pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            wmask_q  <= req_wmask_i;
            len_q    <= req_len_i;
            beat_cnt <= '0;
            if (req_we_i) begin
              aw_pend <= 1'b1;
              w_pend  <= 1'b1;
              state   <= WR;
            end else begin
              ar_pend <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WR: begin
          // AW and W retire independently; leave once neither is outstanding
          if (M_AXI_AWREADY) aw_pend <= 1'b0;
          if (M_AXI_WREADY)  w_pend  <= 1'b0;
          if ((!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY))
            state <= WR_RESP;
        end
        WR_RESP: begin
          if (M_AXI_BVALID && rsp_ready_i) state <= IDLE;
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            ar_pend <= 1'b0;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (M_AXI_RLAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state == IDLE);

  assign M_AXI_AWID    = ID;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWBURST = INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWVALID = aw_pend;

  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wmask_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = w_pend;

  assign M_AXI_BREADY  = (state == WR_RESP) && rsp_ready_i;

  assign M_AXI_ARID    = ID;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARBURST = INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARVALID = ar_pend;

  assign M_AXI_RREADY  = (state == RD_DATA) && rsp_ready_i;

  // Response channel is a straight pass-through of B or R depending on phase
  assign rsp_valid_o = ((state == WR_RESP) && M_AXI_BVALID) ||
                       ((state == RD_DATA) && M_AXI_RVALID);
  assign rsp_rdata_o = (state == RD_DATA) ? M_AXI_RDATA : '0;
  assign rsp_last_o  = (state == WR_RESP) ? 1'b1 :
                       (state == RD_DATA) ? M_AXI_RLAST : 1'b0;

`ifdef AXI_MST_ERR_CHECK_EN
  logic err_sticky;
  logic b_err;
  logic r_err;

  assign b_err = (M_AXI_BRESP != 2'b00) || (M_AXI_BID != ID);
  assign r_err = err_sticky || (M_AXI_RRESP != 2'b00) || (M_AXI_RID != ID) ||
                 (M_AXI_RLAST && (beat_cnt != len_q)) ||
                 (!M_AXI_RLAST && (beat_cnt == len_q));

  // Once the burst overruns len every further beat is flagged until RLAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (state == IDLE) begin
      err_sticky <= 1'b0;
    end else if (r_hs && !M_AXI_RLAST && (beat_cnt == len_q)) begin
      err_sticky <= 1'b1;
    end
  end

  assign rsp_err_o = rsp_valid_o &&
                     (((state == WR_RESP) && b_err) || ((state == RD_DATA) && r_err));
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RRESP, beat_cnt};
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_mst_bridge.sv
// tb/tb_axi_mst_bridge.sv - table-driven and randomized bench for axi_mst_bridge with a
// transaction-level slave and response reference model.
module tb_axi_mst_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int ID = 3;
`ifdef AXI_MST_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wmask;
  logic [7:0]    req_len;
  logic          rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [DW-1:0] rsp_rdata;

  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_mst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          len;
    int          aw_dly, w_dly, ar_dly, b_dly;
    int          stall_beat, stall_n;
    int          bad_beat;
    int          last_beat;
    bit          bad_b;
    int          abort_beat;
    bit          exp_err;
    int          exp_beats;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic vec_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] wm, input int len, input int aw_d, input int w_d,
                              input int b_d, input int sb, input int sn, input int bad,
                              input int lastb, input bit badb, input int abort,
                              input bit xerr, input int xbeats);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.wmask = wm; v.len = len;
    v.aw_dly = aw_d; v.w_dly = w_d; v.ar_dly = aw_d; v.b_dly = b_d;
    v.stall_beat = sb; v.stall_n = sn; v.bad_beat = bad; v.last_beat = lastb;
    v.bad_b = badb; v.abort_beat = abort; v.exp_err = xerr; v.exp_beats = xbeats;
    return v;
  endfunction

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = IW'(ID);
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = IW'(ID);
    rsp_ready = 0;
  endtask

  // Enters somewhere after a rising edge, leaves 2ns after the rising edge that follows
  // the final response handshake.
  task automatic run_txn(input vec_t v, input int stall_pct, input int gap_pct);
    bit aw_done = 0, w_done = 0, ar_done = 0, bv = 0, rv = 0, done = 0, aborted = 0, any_err = 0;
    int b = 0, nrsp = 0, bgap = v.b_dly, stall_left = v.stall_n;
    bit exp_e, is_last;

    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_wmask = v.wmask; req_len = 8'(v.len);
    #1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    req_len = 8'($urandom);

    for (int k = 1; k <= 700 && !done; k++) begin
      slave_idle();
      if (v.we) begin
        awready = (k > v.aw_dly);
        wready  = (k > v.w_dly);
        if (aw_done && w_done && !bv) begin
          if (bgap > 0) bgap--; else bv = 1;
        end
        bvalid = bv; bresp = v.bad_b ? 2'b10 : 2'b00;
      end else begin
        arready = (k > v.ar_dly);
        if (ar_done && !rv && ($urandom % 100 >= gap_pct)) rv = 1;
        is_last = (b == v.last_beat);
        rvalid = rv; rdata = beat_data(v.addr, b); rlast = is_last;
        rresp = (b == v.bad_beat) ? 2'b10 : 2'b00;
      end
      if (!v.we && rv && b == v.stall_beat && stall_left > 0) begin
        rsp_ready = 0; stall_left--;
      end else begin
        rsp_ready = ($urandom % 100 >= stall_pct);
      end
      #1;
      chk("req_ready_busy", req_ready, 0);
      if (k == 1) begin
        if (v.we) chk("aw_w_cycle1", {awvalid, wvalid}, 2'b11);
        else chk("ar_cycle1", arvalid, 1);
      end
      if (v.we) begin
        if (!aw_done) begin
          chk("awvalid_held", awvalid, 1);
          chk("awaddr", awaddr, v.addr);
          chk("awlen", awlen, 0);
          if (awready) aw_done = 1;
        end else chk("awvalid_clear", awvalid, 0);
        if (!w_done) begin
          chk("wvalid_held", wvalid, 1);
          chk("wdata", wdata, v.wdata);
          chk("wstrb", wstrb, v.wmask);
          chk("wlast", wlast, 1);
          if (wready) w_done = 1;
        end else chk("wvalid_clear", wvalid, 0);
        chk("rsp_valid_b", rsp_valid, bv);
        if (bv) begin
          chk("bready", bready, rsp_ready);
          chk("wr_rsp_last", rsp_last, 1);
          chk("wr_rsp_rdata", rsp_rdata, 0);
          chk("wr_rsp_err", rsp_err, ERR_EN && v.bad_b);
          if (rsp_ready) begin nrsp++; any_err |= rsp_err; done = 1; end
        end
      end else begin
        if (!ar_done) begin
          chk("arvalid_held", arvalid, 1);
          chk("araddr", araddr, v.addr);
          chk("arlen", arlen, v.len);
          if (arready) ar_done = 1;
        end else chk("arvalid_clear", arvalid, 0);
        chk("rsp_valid_r", rsp_valid, rv);
        if (rv) begin
          exp_e = ERR_EN && ((b == v.bad_beat) || (b > v.len) || ((b == v.len) != is_last));
          chk("rd_rdata", rsp_rdata, beat_data(v.addr, b));
          chk("rd_last", rsp_last, is_last);
          chk("rready", rready, rsp_ready);
          chk("rd_err", rsp_err, exp_e);
          if (b == v.abort_beat) begin
            #1 rst_n = 0;
            #1;
            chk("abort_rready", rready, 0);
            chk("abort_arvalid", arvalid, 0);
            chk("abort_rsp_valid", rsp_valid, 0);
            chk("abort_awvalid", {awvalid, wvalid}, 0);
            slave_idle();
            @(posedge clk); #1;
            rst_n = 1;
            aborted = 1;
            break;
          end
          if (rsp_ready) begin
            nrsp++; any_err |= rsp_err; b++; rv = 0;
            if (is_last) done = 1;
          end
        end
      end
      @(posedge clk); #1;
    end

    if (!done && !aborted) chk("txn_timeout", 0, 1);
    slave_idle();
    #1;
    chk("req_ready_after", req_ready, 1);
    chk("rsp_valid_after", rsp_valid, 0);
    chk("rsp_count", nrsp, v.exp_beats);
    chk("any_err", any_err, ERR_EN && v.exp_err);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t r;
    int len, lastb, bad;

    //       we  addr      wdata        wm   len aw w  b  sb  sn bad lastb bb abort xerr beats
    vecs.push_back(mk(1, 32'h100,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0, -1, 0, -1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(1, 32'h100,  32'h12345678, 4'h5, 0, 3, 0, 0, -1, 0, -1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(1, 32'h104,  32'hCAFEF00D, 4'h8, 0, 0, 2, 3, -1, 0, -1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(0, 32'h200,  32'h0,        4'h0, 3, 0, 0, 0,  1, 2, -1, 3, 0, -1, 0, 4));
    vecs.push_back(mk(1, 32'h208,  32'hA5A5A5A5, 4'h3, 0, 0, 0, 0, -1, 0, -1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(0, 32'h300,  32'h0,        4'h0, 0, 0, 0, 0, -1, 0, -1, 0, 0, -1, 0, 1));
    vecs.push_back(mk(0, 32'h400,  32'h0,        4'h0, 3, 1, 0, 0, -1, 0,  1, 3, 0, -1, 1, 4));
    vecs.push_back(mk(0, 32'h500,  32'h0,        4'h0, 3, 0, 0, 0, -1, 0, -1, 1, 0, -1, 1, 2));
    vecs.push_back(mk(0, 32'h600,  32'h0,        4'h0, 2, 0, 0, 0, -1, 0, -1, 4, 0, -1, 1, 5));
    vecs.push_back(mk(1, 32'h700,  32'h0BADF00D, 4'hF, 0, 1, 1, 1, -1, 0, -1, 0, 1, -1, 1, 1));
    vecs.push_back(mk(0, 32'h800,  32'h0,        4'h0, 3, 0, 0, 0, -1, 0, -1, 3, 0,  1, 0, 1));
    vecs.push_back(mk(0, 32'h900,  32'h0,        4'h0, 5, 0, 0, 0, -1, 0, -1, 5, 0, -1, 0, 6));
    vecs.push_back(mk(0, 32'h1000, 32'h0,        4'h0, 255, 2, 0, 0, -1, 0, -1, 255, 0, -1, 0, 256));

    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; req_len = 0;
    slave_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_rsp", {rsp_last, rsp_err, rsp_rdata}, 0);
    chk("rst_ids", {awid, arid}, {IW'(ID), IW'(ID)});
    chk("rst_size_burst", {awsize, arsize, awburst, arburst}, {3'd2, 3'd2, 2'b01, 2'b01});
    chk("rst_wlast_len", {wlast, awlen}, {1'b1, 8'd0});
    chk("rst_const", {awlock, awcache, awprot, arlock, arcache, arprot}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_txn(vecs[i], 0, 0);

    for (int i = 0; i < 40; i++) begin
      len   = $urandom % 8;
      lastb = ($urandom % 6 == 0) ? int'($urandom % (len + 1)) : len;
      bad   = ($urandom % 5 == 0) ? int'($urandom % (lastb + 1)) : -1;
      r = mk($urandom % 2, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), len,
             $urandom % 4, $urandom % 4, $urandom % 3, -1, 0, bad, lastb,
             ($urandom % 6 == 0), -1, 0, 0);
      r.ar_dly = $urandom % 4;
      r.exp_beats = r.we ? 1 : lastb + 1;
      r.exp_err   = r.we ? r.bad_b : ((bad >= 0) || (lastb != len));
      run_txn(r, 30, 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
